apb_slave: RTL and testbench
============================

APB_SLAVE -- requirements
Module: apb_slave

Interface
REQ-001 Parameters: none; address and data widths SHALL be fixed at 8 bits.
REQ-002 pclk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 preset_n  in  1  reset, asynchronous, active-low.
REQ-004 psel  in  1  APB select.
REQ-005 penable  in  1  APB enable (access phase).
REQ-006 pwrite  in  1  1=write, 0=read.
REQ-007 paddr  in  8  register address.
REQ-008 pwdata  in  8  write data.
REQ-009 prdata  out  8  read data.
REQ-010 pready  out  1  transfer complete.
REQ-011 pslverr  out  1  transfer error.
REQ-012 over  in  1  timer overflow event, level sampled each pclk.
REQ-013 under  in  1  timer underflow event, level sampled each pclk.
REQ-014 updown  out  1  count direction, TCR[5].
REQ-015 clk_s  out  2  timer clock prescale select, TCR[1:0].
REQ-016 en  out  1  timer enable, TCR[4].
REQ-017 inter_en  out  1  interrupt enable, TCR[3].
REQ-018 init_cnt  out  1  counter load/initialise request, TCR[7], level (not self-clearing).
REQ-019 timer_val  out  8  reload/compare value, TDR[7:0].

Function
REQ-020 Register map SHALL be: 0x00 TCR (R/W), 0x01 TSR (status), 0x02 TDR (R/W); any other address SHALL be invalid.
REQ-021 TCR bits 6 and 2 SHALL be reserved: writes ignored, read as 0.
REQ-022 pready SHALL equal psel & penable (zero wait states; every access completes in its first access-phase cycle).
REQ-023 pslverr SHALL be 1 only when psel & penable and the address is invalid; otherwise 0.
REQ-024 A write SHALL commit at the pclk edge where psel & penable & pwrite & !pslverr; setup-phase cycles SHALL NOT modify state.
REQ-025 prdata SHALL present the addressed register combinationally when psel & !pwrite and the address is valid, and SHALL be 0x00 otherwise.
REQ-026 Writes to invalid addresses SHALL change no state.
REQ-027 Control outputs SHALL reflect register contents directly, updating the cycle after the committing edge.

Reset
REQ-028 While preset_n=0, TCR, TSR and TDR SHALL clear to 0x00 immediately, independent of pclk.
REQ-029 During reset, all control outputs SHALL be 0, timer_val 0x00, pready and pslverr 0, and prdata 0x00 when not selected.
REQ-030 Reset asserted mid-transfer SHALL abort it with no register update; the transfer is not resumed after release.

Configuration
REQ-031 With macro APB_SLAVE_STATUS_REG_EN defined, TSR SHALL exist: bit0 OVF set when over=1, bit1 UDF set when under=1 at a pclk edge; both flags sticky; bits 7:2 read 0.
REQ-032 With APB_SLAVE_STATUS_REG_EN defined, writing 1 to a TSR bit SHALL clear it, writing 0 SHALL leave it; a set event and a clear in the same cycle SHALL leave the flag set.
REQ-033 Without APB_SLAVE_STATUS_REG_EN, TSR SHALL not exist, address 0x01 SHALL be invalid (pslverr=1), and over/under SHALL be ignored.

Verification
REQ-034 Reset, then read 0x00, 0x01, 0x02 -> prdata 0x00 each, pslverr=0.
REQ-035 Write 0x64 to 0x02, read 0x02 -> prdata 0x64, timer_val=0x64, pslverr=0.
REQ-036 Write 0x80 to 0x00 -> init_cnt=1, others 0; then write 0x38 -> init_cnt=0, updown=1, en=1, inter_en=1, clk_s=00; readback 0x38.
REQ-037 Write 0xFF to 0x00 -> readback 0xBB; write or read to 0x05 -> pslverr=1, pready=1, registers unchanged.
REQ-038 (STATUS_REG_EN) Pulse over for 1 cycle -> TSR reads 0x01; pulse under -> 0x03; write 0x01 to 0x01 -> reads 0x02; assert over in the same cycle as a write of 0x01 -> bit0 stays 1.
REQ-039 Assert preset_n=0 between psel and penable of a write to 0x02 -> TDR remains 0x00 after release.

Source files
------------

// File: rtl/apb_slave.sv
// APB slave holding the timer control (TCR), status (TSR) and data (TDR) registers.
// Define APB_SLAVE_STATUS_REG_EN to build the sticky overflow/underflow status register.
module apb_slave (
  input  logic       pclk,
  input  logic       preset_n,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  input  logic       over,
  input  logic       under,
  output logic       updown,
  output logic [1:0] clk_s,
  output logic       en,
  output logic       inter_en,
  output logic       init_cnt,
  output logic [7:0] timer_val
);

  localparam logic [7:0] ADDR_TCR = 8'h00;
  localparam logic [7:0] ADDR_TSR = 8'h01;
  localparam logic [7:0] ADDR_TDR = 8'h02;
  localparam logic [7:0] TCR_MASK = 8'hBB;

  logic [7:0] r_tcr;
  logic [7:0] r_tdr;
  logic       w_access;
  logic       w_addr_valid;
  logic       w_wr_en;
  logic       w_wr_tcr;
  logic       w_wr_tdr;

`ifdef APB_SLAVE_STATUS_REG_EN
  logic [1:0] r_tsr;
  logic [1:0] w_tsr_clr;
  logic       w_wr_tsr;

  assign w_addr_valid = (paddr == ADDR_TCR) || (paddr == ADDR_TSR) || (paddr == ADDR_TDR);
`else
  logic w_unused_events;

  // Status register is absent, so the timer events have no effect.
  assign w_unused_events = over ^ under;
  assign w_addr_valid    = (paddr == ADDR_TCR) || (paddr == ADDR_TDR);
`endif

  // Responses are held low while reset is asserted, even mid-transfer.
  assign w_access = psel & penable & preset_n;
  assign pready   = w_access;
  assign pslverr  = w_access & ~w_addr_valid;
  assign w_wr_en  = w_access & pwrite & w_addr_valid;
  assign w_wr_tcr = w_wr_en & (paddr == ADDR_TCR);
  assign w_wr_tdr = w_wr_en & (paddr == ADDR_TDR);

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_tcr <= 8'h00;
      r_tdr <= 8'h00;
    end else begin
      if (w_wr_tcr) r_tcr <= pwdata & TCR_MASK;
      if (w_wr_tdr) r_tdr <= pwdata;
    end
  end

`ifdef APB_SLAVE_STATUS_REG_EN
  assign w_wr_tsr  = w_wr_en & (paddr == ADDR_TSR);
  assign w_tsr_clr = w_wr_tsr ? pwdata[1:0] : 2'b00;

  // Write-one-to-clear flags; a same-cycle event wins over the clear.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_tsr <= 2'b00;
    end else begin
      r_tsr <= (r_tsr & ~w_tsr_clr) | {under, over};
    end
  end
`endif

  always_comb begin
    prdata = 8'h00;
    if (psel && !pwrite) begin
      case (paddr)
        ADDR_TCR: prdata = r_tcr;
`ifdef APB_SLAVE_STATUS_REG_EN
        ADDR_TSR: prdata = {6'b000000, r_tsr};
`endif
        ADDR_TDR: prdata = r_tdr;
        default:  prdata = 8'h00;
      endcase
    end else begin
      prdata = 8'h00;
    end
  end

  assign init_cnt  = r_tcr[7];
  assign updown    = r_tcr[5];
  assign en        = r_tcr[4];
  assign inter_en  = r_tcr[3];
  assign clk_s     = r_tcr[1:0];
  assign timer_val = r_tdr;

endmodule

// File: tb/tb_apb_slave.sv
// Directed self-checking bench for apb_slave; honours APB_SLAVE_STATUS_REG_EN like the RTL.
module tb_apb_slave;

  logic       pclk = 1'b0;
  logic       preset_n;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic [7:0] prdata;
  logic       pready, pslverr;
  logic       over, under;
  logic       updown, en, inter_en, init_cnt;
  logic [1:0] clk_s;
  logic [7:0] timer_val;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] rd_data;
  logic       rd_err, rd_rdy, wr_err, wr_rdy;

  apb_slave dut (
    .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .over(over), .under(under), .updown(updown), .clk_s(clk_s), .en(en),
    .inter_en(inter_en), .init_cnt(init_cnt), .timer_val(timer_val)
  );

  always #5 pclk = ~pclk;

  task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    penable = 1'b1;
    #1;
    wr_err = pslverr; wr_rdy = pready;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge pclk); #1;
    penable = 1'b1;
    #1;
    rd_data = prdata; rd_err = pslverr; rd_rdy = pready;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] exp_err;
    preset_n = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00; pwdata = 8'h00;
    over = 1'b0; under = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    n_checks++;
    if ({init_cnt, updown, en, inter_en, clk_s, timer_val, pready, pslverr, prdata} !== 24'h000000) begin
      $display("FAIL reset_outputs got ctl=%b tv=%h rdy=%b err=%b rd=%h exp all zero",
               {init_cnt, updown, en, inter_en, clk_s}, timer_val, pready, pslverr, prdata);
      n_errors++;
    end
    preset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apb_read(i[7:0]);
`ifdef APB_SLAVE_STATUS_REG_EN
      exp_err = 8'h00;
`else
      exp_err = (i == 1) ? 8'h01 : 8'h00;
`endif
      n_checks++;
      if (rd_data !== 8'h00 || rd_err !== exp_err[0]) begin
        $display("FAIL reset_read addr=%0d got data=%h err=%b exp data=00 err=%b", i, rd_data, rd_err, exp_err[0]);
        n_errors++;
      end
    end
  endtask

  task automatic test_tdr();
    apb_write(8'h02, 8'h64);
    n_checks++;
    if (wr_err !== 1'b0 || wr_rdy !== 1'b1) begin
      $display("FAIL tdr_write_resp got err=%b rdy=%b exp err=0 rdy=1", wr_err, wr_rdy);
      n_errors++;
    end
    apb_read(8'h02);
    n_checks++;
    if (rd_data !== 8'h64 || rd_err !== 1'b0 || timer_val !== 8'h64) begin
      $display("FAIL tdr_read got data=%h err=%b tv=%h exp data=64 err=0 tv=64", rd_data, rd_err, timer_val);
      n_errors++;
    end
  endtask

  task automatic test_tcr();
    apb_write(8'h00, 8'h80);
    n_checks++;
    if ({init_cnt, updown, en, inter_en, clk_s} !== 6'b100000) begin
      $display("FAIL tcr_init_cnt got %b exp 100000", {init_cnt, updown, en, inter_en, clk_s});
      n_errors++;
    end
    apb_write(8'h00, 8'h38);
    n_checks++;
    if ({init_cnt, updown, en, inter_en, clk_s} !== 6'b011100) begin
      $display("FAIL tcr_ctrl got %b exp 011100", {init_cnt, updown, en, inter_en, clk_s});
      n_errors++;
    end
    apb_read(8'h00);
    n_checks++;
    if (rd_data !== 8'h38 || rd_err !== 1'b0) begin
      $display("FAIL tcr_read got data=%h err=%b exp data=38 err=0", rd_data, rd_err);
      n_errors++;
    end
  endtask

  task automatic test_reserved_invalid();
    apb_write(8'h00, 8'hFF);
    apb_read(8'h00);
    n_checks++;
    if (rd_data !== 8'hBB || {init_cnt, updown, en, inter_en, clk_s} !== 6'b111111) begin
      $display("FAIL tcr_reserved got data=%h ctl=%b exp data=bb ctl=111111",
               rd_data, {init_cnt, updown, en, inter_en, clk_s});
      n_errors++;
    end
    apb_write(8'h05, 8'h00);
    n_checks++;
    if (wr_err !== 1'b1 || wr_rdy !== 1'b1) begin
      $display("FAIL invalid_write_resp got err=%b rdy=%b exp err=1 rdy=1", wr_err, wr_rdy);
      n_errors++;
    end
    apb_read(8'h05);
    n_checks++;
    if (rd_err !== 1'b1 || rd_rdy !== 1'b1 || rd_data !== 8'h00) begin
      $display("FAIL invalid_read_resp got err=%b rdy=%b data=%h exp err=1 rdy=1 data=00", rd_err, rd_rdy, rd_data);
      n_errors++;
    end
    apb_read(8'h00);
    n_checks++;
    if (rd_data !== 8'hBB || timer_val !== 8'h64) begin
      $display("FAIL invalid_no_change got tcr=%h tv=%h exp tcr=bb tv=64", rd_data, timer_val);
      n_errors++;
    end
  endtask

  task automatic test_setup_only();
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h02; pwdata = 8'h11;
    @(posedge pclk); #1;
    psel = 1'b0; pwrite = 1'b0;
    @(posedge pclk); #1;
    n_checks++;
    if (timer_val !== 8'h64) begin
      $display("FAIL setup_no_commit got tv=%h exp 64", timer_val);
      n_errors++;
    end
  endtask

`ifdef APB_SLAVE_STATUS_REG_EN
  task automatic test_status();
    @(posedge pclk); #1; over = 1'b1;
    @(posedge pclk); #1; over = 1'b0;
    apb_read(8'h01);
    n_checks++;
    if (rd_data !== 8'h01) begin
      $display("FAIL tsr_ovf got %h exp 01", rd_data);
      n_errors++;
    end
    @(posedge pclk); #1; under = 1'b1;
    @(posedge pclk); #1; under = 1'b0;
    apb_read(8'h01);
    n_checks++;
    if (rd_data !== 8'h03) begin
      $display("FAIL tsr_udf got %h exp 03", rd_data);
      n_errors++;
    end
    apb_write(8'h01, 8'h01);
    apb_read(8'h01);
    n_checks++;
    if (rd_data !== 8'h02) begin
      $display("FAIL tsr_w1c got %h exp 02", rd_data);
      n_errors++;
    end
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h01; pwdata = 8'h01;
    @(posedge pclk); #1;
    penable = 1'b1; over = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; over = 1'b0;
    apb_read(8'h01);
    n_checks++;
    if (rd_data !== 8'h03) begin
      $display("FAIL tsr_set_wins got %h exp 03", rd_data);
      n_errors++;
    end
  endtask
`else
  task automatic test_status();
    @(posedge pclk); #1; over = 1'b1; under = 1'b1;
    @(posedge pclk); #1; over = 1'b0; under = 1'b0;
    apb_read(8'h01);
    n_checks++;
    if (rd_data !== 8'h00 || rd_err !== 1'b1) begin
      $display("FAIL tsr_absent got data=%h err=%b exp data=00 err=1", rd_data, rd_err);
      n_errors++;
    end
  endtask
`endif

  task automatic test_reset_mid();
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h02; pwdata = 8'h5A;
    #2 preset_n = 1'b0;
    #1;
    n_checks++;
    if (timer_val !== 8'h00 || {init_cnt, updown, en, inter_en, clk_s} !== 6'b000000) begin
      $display("FAIL async_reset got tv=%h ctl=%b exp tv=00 ctl=000000",
               timer_val, {init_cnt, updown, en, inter_en, clk_s});
      n_errors++;
    end
    @(posedge pclk); #1;
    penable = 1'b1;
    #1;
    n_checks++;
    if (pready !== 1'b0 || pslverr !== 1'b0) begin
      $display("FAIL reset_resp got rdy=%b err=%b exp rdy=0 err=0", pready, pslverr);
      n_errors++;
    end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    #2 preset_n = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    apb_read(8'h02);
    n_checks++;
    if (rd_data !== 8'h00 || timer_val !== 8'h00) begin
      $display("FAIL reset_abort got data=%h tv=%h exp data=00 tv=00", rd_data, timer_val);
      n_errors++;
    end
  endtask

  initial begin
    test_reset();
    test_tdr();
    test_tcr();
    test_reserved_invalid();
    test_setup_only();
    test_status();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
